// File: rtl/ctrl_pkg.sv
// Control-word layout, opcode encodings and the opcode decoder for the SimpleRISC control pipe.
// Pure combinational helpers; no state, no flow control.
package ctrl_pkg;

    localparam int CW = 23;

    localparam int B_ST      = 0;
    localparam int B_LD      = 1;
    localparam int B_BEQ     = 2;
    localparam int B_BGT     = 3;
    localparam int B_RET     = 4;
    localparam int B_IMM     = 5;
    localparam int B_WB      = 6;
    localparam int B_UBRANCH = 7;
    localparam int B_CALL    = 8;
    localparam int B_ADD     = 9;
    localparam int B_SUB     = 10;
    localparam int B_CMP     = 11;
    localparam int B_MUL     = 12;
    localparam int B_DIV     = 13;
    localparam int B_MOD     = 14;
    localparam int B_LSL     = 15;
    localparam int B_LSR     = 16;
    localparam int B_ASR     = 17;
    localparam int B_OR      = 18;
    localparam int B_AND     = 19;
    localparam int B_NOT     = 20;
    localparam int B_MOV     = 21;
    localparam int B_ILLEGAL = 22;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    typedef logic [CW-1:0] ctrl_word_t;

    function automatic ctrl_word_t decode_op(input logic [5:0] opcode);
        ctrl_word_t cw;
        cw = '0;
        case (opcode[5:1])
            OP_ADD:  begin cw[B_ADD] = 1'b1; cw[B_WB] = 1'b1; end
            OP_SUB:  begin cw[B_SUB] = 1'b1; cw[B_WB] = 1'b1; end
            OP_MUL:  begin cw[B_MUL] = 1'b1; cw[B_WB] = 1'b1; end
            OP_DIV:  begin cw[B_DIV] = 1'b1; cw[B_WB] = 1'b1; end
            OP_MOD:  begin cw[B_MOD] = 1'b1; cw[B_WB] = 1'b1; end
            OP_CMP:  cw[B_CMP] = 1'b1;
            OP_AND:  begin cw[B_AND] = 1'b1; cw[B_WB] = 1'b1; end
            OP_OR:   begin cw[B_OR]  = 1'b1; cw[B_WB] = 1'b1; end
            OP_NOT:  begin cw[B_NOT] = 1'b1; cw[B_WB] = 1'b1; end
            OP_MOV:  begin cw[B_MOV] = 1'b1; cw[B_WB] = 1'b1; end
            OP_LSL:  begin cw[B_LSL] = 1'b1; cw[B_WB] = 1'b1; end
            OP_LSR:  begin cw[B_LSR] = 1'b1; cw[B_WB] = 1'b1; end
            OP_ASR:  begin cw[B_ASR] = 1'b1; cw[B_WB] = 1'b1; end
            // ld/st reuse the adder for address generation
            OP_LD:   begin cw[B_LD] = 1'b1; cw[B_ADD] = 1'b1; cw[B_WB] = 1'b1; end
            OP_ST:   begin cw[B_ST] = 1'b1; cw[B_ADD] = 1'b1; end
            OP_BEQ:  cw[B_BEQ] = 1'b1;
            OP_BGT:  cw[B_BGT] = 1'b1;
            OP_B:    cw[B_UBRANCH] = 1'b1;
            OP_CALL: begin cw[B_CALL] = 1'b1; cw[B_UBRANCH] = 1'b1; cw[B_WB] = 1'b1; end
            OP_RET:  begin cw[B_RET] = 1'b1; cw[B_UBRANCH] = 1'b1; end
            default: cw[B_ILLEGAL] = 1'b1;
        endcase
        cw[B_IMM] = opcode[0];
        return cw;
    endfunction

endpackage

// File: rtl/muldiv_occupancy_ctr.sv
// Counts the extra cycles a MUL/DIV/MOD must hold the execute stage; busy while non-zero.
// Loads on entry to execute, freezes on stall, cleared by synchronous reset.
module muldiv_occupancy_ctr #(
    parameter int MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic stall,
    output logic busy
);
    localparam int CNT_W = $clog2(MULDIV_LAT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!stall) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else if (load && (MULDIV_LAT > 1)) begin
                cnt_d = LOAD_VAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Decodes opcodes into control words and carries them through NUM_STAGES valid-tagged stages.
// Zero-latency decode into stage 0; in_ready drops on stall_ext, flush or a multi-cycle op in execute.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int EX_STAGE   = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 opcode,
    input  logic                       stall_ext,
    input  logic                       flush,
    output logic [NUM_STAGES*CW-1:0]   stage_ctrl,
    output logic [NUM_STAGES-1:0]      stage_valid,
    output logic                       busy
);
    ctrl_word_t            ctrl_q [NUM_STAGES];
    ctrl_word_t            ctrl_d [NUM_STAGES];
    logic [NUM_STAGES-1:0] vld_q, vld_d;
    ctrl_word_t            dec_word;
    logic                  accept;
    logic                  ex_load;

    assign dec_word = decode_op(opcode);
    assign in_ready = !stall_ext && !busy && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        if (!stall_ext) begin
            for (int s = NUM_STAGES - 1; s > 0; s--) begin
                if (!busy || s > EX_STAGE + 1) begin
                    vld_d[s]  = vld_q[s-1];
                    ctrl_d[s] = ctrl_q[s-1];
                end else if (s == EX_STAGE + 1) begin
                    // execute is held, so the stage behind it drains a bubble
                    vld_d[s]  = 1'b0;
                    ctrl_d[s] = '0;
                end
            end
            if (!busy) begin
                vld_d[0]  = accept;
                ctrl_d[0] = accept ? dec_word : '0;
            end
        end
        // the taken branch sits in execute; only the younger stages are squashed
        if (flush) begin
            for (int s = 0; s < EX_STAGE; s++) begin
                vld_d[s]  = 1'b0;
                ctrl_d[s] = '0;
            end
        end
    end

    assign ex_load = !stall_ext && !busy && vld_d[EX_STAGE] &&
                     (ctrl_d[EX_STAGE][B_MUL] || ctrl_d[EX_STAGE][B_DIV] || ctrl_d[EX_STAGE][B_MOD]);

    muldiv_occupancy_ctr #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .load  (ex_load),
        .stall (stall_ext),
        .busy  (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                ctrl_q[s] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_out
        assign stage_ctrl[g*CW +: CW] = ctrl_q[g];
    end
    assign stage_valid = vld_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: a cycle-level reference pipe checked every cycle,
// plus literal expectations for decode words, occupancy timing, flush and reset.
module tb_ctrl_decode_pipe;
    localparam int NS  = 3;
    localparam int EX  = 1;
    localparam int LAT = 4;
    localparam int W   = 23;

    localparam logic [5:0] OC_ADD = 6'b000000;
    localparam logic [5:0] OC_SUB = 6'b000010;
    localparam logic [5:0] OC_MUL = 6'b000100;
    localparam logic [5:0] OC_OR  = 6'b001110;
    localparam logic [5:0] OC_LD  = 6'b011100;
    localparam logic [5:0] OC_BEQ = 6'b100000;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, stall_ext, flush, busy;
    logic [5:0]      opcode;
    logic [NS*W-1:0] stage_ctrl;
    logic [NS-1:0]   stage_valid;

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_decode_pipe #(.NUM_STAGES(NS), .EX_STAGE(EX), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .stall_ext(stall_ext), .flush(flush), .stage_ctrl(stage_ctrl),
        .stage_valid(stage_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] b(input int n);
        logic [W-1:0] one;
        one = 1;
        return one << n;
    endfunction

    // Reference decode written straight from the opcode table.
    function automatic logic [W-1:0] ref_decode(input logic [5:0] oc);
        logic [W-1:0] m;
        int op;
        op = int'(oc[5:1]);
        case (op)
            0:  m = b(9)  | b(6);
            1:  m = b(10) | b(6);
            2:  m = b(12) | b(6);
            3:  m = b(13) | b(6);
            4:  m = b(14) | b(6);
            5:  m = b(11);
            6:  m = b(19) | b(6);
            7:  m = b(18) | b(6);
            8:  m = b(20) | b(6);
            9:  m = b(21) | b(6);
            10: m = b(15) | b(6);
            11: m = b(16) | b(6);
            12: m = b(17) | b(6);
            14: m = b(1)  | b(9) | b(6);
            15: m = b(0)  | b(9);
            16: m = b(2);
            17: m = b(3);
            18: m = b(7);
            19: m = b(8)  | b(7) | b(6);
            20: m = b(4)  | b(7);
            default: m = b(22);
        endcase
        if (oc[0]) m = m | b(5);
        return m;
    endfunction

    // Reference pipe: per-stage records plus "cycles the execute op must still stay".
    logic [W-1:0] m_ctrl [NS];
    bit           m_vld  [NS];
    int           m_left = 0;
    bit           m_init = 0;

    always @(posedge clk) begin
        logic [W-1:0] nc [NS];
        bit           nv [NS];
        bit           rdy;
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                m_ctrl[s] = '0;
                m_vld[s]  = 0;
            end
            m_left = 0;
            m_init = 1;
        end else if (m_init) begin
            rdy = !stall_ext && (m_left == 0) && !flush;
            nc  = m_ctrl;
            nv  = m_vld;
            if (!stall_ext && m_left > 0) begin
                for (int s = NS - 1; s > EX + 1; s--) begin
                    nv[s] = m_vld[s-1];
                    nc[s] = m_ctrl[s-1];
                end
                nv[EX+1] = 0;
                nc[EX+1] = '0;
                m_left   = m_left - 1;
            end else if (!stall_ext) begin
                for (int s = NS - 1; s > 0; s--) begin
                    nv[s] = m_vld[s-1];
                    nc[s] = m_ctrl[s-1];
                end
                nv[0] = in_valid && rdy;
                nc[0] = nv[0] ? ref_decode(opcode) : '0;
                if (nv[EX] && (nc[EX][12] || nc[EX][13] || nc[EX][14]) && LAT > 1)
                    m_left = LAT - 1;
            end
            if (flush) begin
                for (int s = 0; s < EX; s++) begin
                    nv[s] = 0;
                    nc[s] = '0;
                end
            end
            m_ctrl = nc;
            m_vld  = nv;
        end
    end

    always @(negedge clk) begin
        logic [NS*W-1:0] ec;
        logic [NS-1:0]   ev;
        if (m_init) begin
            for (int s = 0; s < NS; s++) begin
                ec[s*W +: W] = m_ctrl[s];
                ev[s]        = m_vld[s];
            end
            chk("model_valid", 128'(stage_valid), 128'(ev));
            chk("model_ctrl", 128'(stage_ctrl), 128'(ec));
            chk("model_busy", 128'(busy), 128'(m_left > 0));
            chk("model_in_ready", 128'(in_ready), 128'(!stall_ext && m_left == 0 && !flush));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [5:0]   sweep_oc  [4] = '{6'b100110, 6'b101000, 6'b000001, 6'b101010};
    logic [W-1:0] sweep_exp [4] = '{23'h0001C0, 23'h000090, 23'h000260, 23'h400000};

    initial begin
        int busy_n, mul_s1, mul_s2_at, add_s2_at, bub_s2;
        rst = 1; in_valid = 1; opcode = OC_LD; stall_ext = 0; flush = 0;

        // reset with a valid opcode presented
        cyc(); cyc();
        chk("rst_valid", 128'(stage_valid), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_ctrl", 128'(stage_ctrl), 0);
        rst = 0;
        #1 chk("rel_in_ready", 128'(in_ready), 1);
        cyc();
        chk("ld_valid", 128'(stage_valid), 128'(3'b001));
        chk("ld_word", 128'(stage_ctrl[0 +: W]), 128'(23'h000242));

        for (int i = 0; i < 4; i++) begin
            opcode = sweep_oc[i];
            cyc();
            chk("sweep_word", 128'(stage_ctrl[0 +: W]), 128'(sweep_exp[i]));
        end
        in_valid = 0;
        cyc(); cyc(); cyc();

        // mul followed by add
        in_valid = 1; opcode = OC_MUL; cyc();
        chk("mul_word", 128'(stage_ctrl[0 +: W]), 128'(23'h001040));
        opcode = OC_ADD; cyc();
        in_valid = 0;
        busy_n = 0; mul_s1 = 0; mul_s2_at = -1; add_s2_at = -1; bub_s2 = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_n++;
            if (stage_valid[1] && stage_ctrl[W + 12]) mul_s1++;
            if (i >= 1 && i <= 3 && !stage_valid[2]) bub_s2++;
            if (stage_valid[2] && stage_ctrl[2*W +: W] == 23'h001040 && mul_s2_at < 0) mul_s2_at = i;
            if (stage_valid[2] && stage_ctrl[2*W +: W] == 23'h000240 && add_s2_at < 0) add_s2_at = i;
            cyc();
        end
        chk("mul_busy_cycles", 128'(busy_n), 3);
        chk("mul_ex_cycles", 128'(mul_s1), 4);
        chk("mul_s2_bubbles", 128'(bub_s2), 3);
        chk("mul_s2_at", 128'(mul_s2_at), 4);
        chk("add_s2_at", 128'(add_s2_at), 5);

        // flush while beq is in execute
        in_valid = 1; opcode = OC_SUB; cyc();
        opcode = OC_ADD; cyc();
        opcode = OC_BEQ; cyc();
        in_valid = 0; cyc();
        flush = 1; in_valid = 1; opcode = OC_OR;
        #1 chk("flush_in_ready", 128'(in_ready), 0);
        cyc();
        flush = 0; in_valid = 0;
        chk("flush_valid", 128'(stage_valid), 128'(3'b100));
        chk("flush_beq_s2", 128'(stage_ctrl[2*W +: W]), 128'(23'h000004));
        cyc(); cyc();

        // stall mid-stream, then flush during the stall
        in_valid = 1; opcode = OC_LD; cyc();
        opcode = OC_OR; cyc();
        stall_ext = 1; cyc();
        chk("stall_valid", 128'(stage_valid), 128'(3'b011));
        chk("stall_s0", 128'(stage_ctrl[0 +: W]), 128'(23'h040040));
        flush = 1; cyc();
        chk("stall_flush_valid", 128'(stage_valid), 128'(3'b010));
        chk("stall_flush_s1", 128'(stage_ctrl[W +: W]), 128'(23'h000242));
        stall_ext = 0; flush = 0; in_valid = 0;
        cyc(); cyc(); cyc();

        // stall while mul holds execute
        in_valid = 1; opcode = OC_MUL; cyc();
        opcode = OC_ADD; cyc();
        in_valid = 0;
        mul_s1 = 0; mul_s2_at = -1;
        for (int i = 0; i < 9; i++) begin
            if (stage_valid[1] && stage_ctrl[W + 12]) mul_s1++;
            if (stage_valid[2] && stage_ctrl[2*W + 12] && mul_s2_at < 0) mul_s2_at = i;
            stall_ext = (i == 1 || i == 2);
            cyc();
        end
        stall_ext = 0;
        chk("stall_mul_ex_cycles", 128'(mul_s1), 6);
        chk("stall_mul_s2_at", 128'(mul_s2_at), 6);
        cyc(); cyc();

        // reset while busy with two extra cycles still owed
        in_valid = 1; opcode = OC_MUL; cyc();
        in_valid = 0; cyc();
        cyc();
        chk("pre_rst_busy", 128'(busy), 1);
        rst = 1; cyc();
        rst = 0;
        chk("rst_busy_mid", 128'(busy), 0);
        chk("rst_valid_mid", 128'(stage_valid), 0);
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
